// File: rtl/fp_add4_seq.sv
// Four-operand IEEE-754 single adder: one shared adder, (in1+in2)+(in3+in4) order.
// Optional sticky exception flag when FP_ADD4_EXC_EN is defined.

module Addition_Subtraction (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        AddBar_Sub,
`ifdef FP_ADD4_EXC_EN
  output logic        Exception,
`endif
  output logic [31:0] result
);
  logic        sb, a_big, sl, ss, sticky, rnd, ovf;
  logic        a_spec, b_spec, a_nan, b_nan, a_inf, b_inf;
  logic [31:0] bb, bl, bs;
  logic [7:0]  xl, xs, d8, shcap;
  logic [23:0] ml, ms;
  logic [26:0] ms_sh, n;
  logic [27:0] sum;
  logic [8:0]  e;
  logic [4:0]  lz;
  logic [24:0] mr;

  assign sb     = b[31] ^ AddBar_Sub;
  assign bb     = {sb, b[30:0]};
  assign a_spec = &a[30:23];
  assign b_spec = &b[30:23];
  assign a_nan  = a_spec & (|a[22:0]);
  assign b_nan  = b_spec & (|b[22:0]);
  assign a_inf  = a_spec & ~(|a[22:0]);
  assign b_inf  = b_spec & ~(|b[22:0]);

`ifdef FP_ADD4_EXC_EN
  assign Exception = a_spec | b_spec | ovf;
`endif

  // Align, add/subtract with guard/round/sticky, normalize, round to nearest even.
  always_comb begin
    a_big = (a[30:0] >= b[30:0]);
    bl    = a_big ? a : bb;
    bs    = a_big ? bb : a;
    sl    = bl[31];
    ss    = bs[31];
    xl    = (bl[30:23] == 8'd0) ? 8'd1 : bl[30:23];
    xs    = (bs[30:23] == 8'd0) ? 8'd1 : bs[30:23];
    ml    = {bl[30:23] != 8'd0, bl[22:0]};
    ms    = {bs[30:23] != 8'd0, bs[22:0]};
    d8    = xl - xs;
    if (d8 >= 8'd27) begin
      ms_sh  = '0;
      sticky = |ms;
    end else begin
      ms_sh  = {ms, 3'b000} >> d8;
      sticky = |({ms, 3'b000} & ((27'd1 << d8) - 27'd1));
    end
    ms_sh[0] = ms_sh[0] | sticky;
    sum = (sl == ss) ? ({1'b0, ml, 3'b000} + {1'b0, ms_sh})
                     : ({1'b0, ml, 3'b000} - {1'b0, ms_sh});

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    // Left shift is capped so the exponent never drops below the subnormal floor.
    shcap = xl - 8'd1;
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = {1'b0, xl} + 9'd1;
    end else if ({3'b000, lz} > shcap) begin
      n = sum[26:0] << shcap;
      e = 9'd1;
    end else begin
      n = sum[26:0] << lz;
      e = {1'b0, xl} - {4'b0000, lz};
    end

    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 9'd1;
    end
    ovf = (e >= 9'd255);

    result = {sl, (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
    if (sum == 28'd0) result = {sl & ss, 31'd0};
    if (ovf)          result = {sl, 8'hFF, 23'd0};
    if (a_spec || b_spec) begin
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb)))
        result = 32'h7FC00000;
      else
        result = {(a_inf ? a[31] : sb), 8'hFF, 23'd0};
    end
  end
endmodule

module fp_add4_seq #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic [DW-1:0] in4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          exc
);
  typedef enum logic [2:0] {IDLE, ADD12, ADD34, ADDF, DONE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] op1, op2, op3, op4, op1_n, op2_n, op3_n, op4_n;
  logic [DW-1:0] tmp1, tmp2, tmp1_n, tmp2_n, result_n;
  logic          in_ready_n, out_valid_n;
  logic [DW-1:0] add_a, add_b, add_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      op1       <= '0;
      op2       <= '0;
      op3       <= '0;
      op4       <= '0;
      tmp1      <= '0;
      tmp2      <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      result    <= result_n;
      op1       <= op1_n;
      op2       <= op2_n;
      op3       <= op3_n;
      op4       <= op4_n;
      tmp1      <= tmp1_n;
      tmp2      <= tmp2_n;
    end
  end

  always_comb begin
    state_n     = state;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    result_n    = result;
    op1_n       = op1;
    op2_n       = op2;
    op3_n       = op3;
    op4_n       = op4;
    tmp1_n      = tmp1;
    tmp2_n      = tmp2;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        op1_n      = in1;
        op2_n      = in2;
        op3_n      = in3;
        op4_n      = in4;
        in_ready_n = 1'b0;
        state_n    = ADD12;
      end
      ADD12: begin
        tmp1_n  = add_res;
        state_n = ADD34;
      end
      ADD34: begin
        tmp2_n  = add_res;
        state_n = ADDF;
      end
      ADDF: begin
        result_n    = add_res;
        out_valid_n = 1'b1;
        state_n     = DONE;
      end
      DONE: if (out_valid && out_ready) begin
        out_valid_n = 1'b0;
        in_ready_n  = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Adder operands depend only on state; zero when the adder is idle.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      ADD12: begin add_a = op1;  add_b = op2;  end
      ADD34: begin add_a = op3;  add_b = op4;  end
      ADDF:  begin add_a = tmp1; add_b = tmp2; end
      default: ;
    endcase
  end

`ifdef FP_ADD4_EXC_EN
  logic add_exc, exc_n;

  always_comb begin
    exc_n = exc;
    case (state)
      IDLE: if (in_valid && in_ready) exc_n = 1'b0;
      ADD12, ADD34, ADDF: exc_n = exc | add_exc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) exc <= 1'b0;
    else     exc <= exc_n;
  end
`else
  assign exc = 1'b0;
`endif

  Addition_Subtraction u_add (
    .a          (add_a),
    .b          (add_b),
    .AddBar_Sub (1'b0),
`ifdef FP_ADD4_EXC_EN
    .Exception  (add_exc),
`endif
    .result     (add_res)
  );
endmodule
